// File: rtl/mvm_mac_ctrl.sv
// mvm_mac_ctrl: sequences a pipelined 10x10 saturating MAC to compute y = M*x.
// Loads M (row-major) then x into external sync-read memories, streams one
// row of operands per pass into the MAC, counts MAC result strobes to know
// when the row is complete, and hands the 20-bit result out on y_*.
module mvm_mac_ctrl #(
    parameter int ROWS = 3,
    parameter int COLS = 3,
    parameter int MA_W = $clog2(ROWS*COLS),
    parameter int XA_W = $clog2(COLS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [9:0]      s_data,
    input  logic            s_valid,
    output logic            s_ready,
    output logic            m_wr_en,
    output logic [MA_W-1:0] m_addr,
    output logic [9:0]      m_wdata,
    input  logic [9:0]      m_rdata,
    output logic            x_wr_en,
    output logic [XA_W-1:0] x_addr,
    output logic [9:0]      x_wdata,
    input  logic [9:0]      x_rdata,
    output logic [9:0]      mac_a,
    output logic [9:0]      mac_b,
    output logic            mac_valid_in,
    output logic            mac_clear,
    input  logic [19:0]     mac_f,
    input  logic            mac_valid_out,
    output logic [19:0]     y_data,
    output logic            y_valid,
    input  logic            y_ready
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int PW = $clog2(COLS + 1);

    localparam logic [MA_W-1:0] M_LAST = MA_W'(ROWS*COLS - 1);
    localparam logic [MA_W-1:0] X_LAST = MA_W'(COLS - 1);
    localparam logic [XA_W-1:0] C_LAST = XA_W'(COLS - 1);
    localparam logic [RW-1:0]   R_LAST = RW'(ROWS - 1);
    localparam logic [PW-1:0]   P_DONE = PW'(COLS);

    // CLR_ROW is the single-cycle MAC clear that follows each accepted result.
    typedef enum logic [2:0] {
        CLEAR_INIT,
        LOAD_M,
        LOAD_X,
        ISSUE,
        DRAIN,
        OUT,
        CLR_ROW
    } state_t;

    state_t          state, state_nxt;
    logic [MA_W-1:0] wcnt;
    logic [RW-1:0]   row;
    logic [XA_W-1:0] col;
    logic [PW-1:0]   pcnt;
    logic            issue_d;
    logic [MA_W-1:0] rd_addr;

    // Row-major matrix read address for the element being issued.
    assign rd_addr = MA_W'(row) * MA_W'(COLS) + MA_W'(col);

    // Memory read data lands one cycle after the issue; forward it straight to the MAC.
    assign mac_a        = m_rdata;
    assign mac_b        = x_rdata;
    assign mac_valid_in = issue_d;
    assign m_wdata      = s_data;
    assign x_wdata      = s_data;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= CLEAR_INIT;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR_INIT: state_nxt = LOAD_M;
            LOAD_M:     if (s_valid && wcnt == M_LAST) state_nxt = LOAD_X;
            LOAD_X:     if (s_valid && wcnt == X_LAST) state_nxt = ISSUE;
            ISSUE:      if (col == C_LAST) state_nxt = DRAIN;
            DRAIN:      if (pcnt == P_DONE) state_nxt = OUT;
            OUT:        if (y_ready) state_nxt = CLR_ROW;
            CLR_ROW:    state_nxt = (row == R_LAST) ? LOAD_M : ISSUE;
            default:    state_nxt = CLEAR_INIT;
        endcase
    end

    // Output decode: handshakes, memory strobes/addresses, MAC clear, result valid.
    always_comb begin
        s_ready   = 1'b0;
        m_wr_en   = 1'b0;
        x_wr_en   = 1'b0;
        m_addr    = '0;
        x_addr    = '0;
        mac_clear = 1'b0;
        y_valid   = 1'b0;
        case (state)
            CLEAR_INIT: mac_clear = 1'b1;
            LOAD_M: begin
                s_ready = 1'b1;
                m_wr_en = s_valid;
                m_addr  = wcnt;
            end
            LOAD_X: begin
                s_ready = 1'b1;
                x_wr_en = s_valid;
                x_addr  = wcnt[XA_W-1:0];
            end
            ISSUE: begin
                m_addr = rd_addr;
                x_addr = col;
            end
            OUT:     y_valid   = 1'b1;
            CLR_ROW: mac_clear = 1'b1;
            default: ;
        endcase
    end

    // Load word counter, row/col issue counters, and MAC strobe counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt <= '0;
            row  <= '0;
            col  <= '0;
            pcnt <= '0;
        end else begin
            case (state)
                LOAD_M: if (s_valid) wcnt <= (wcnt == M_LAST) ? '0 : wcnt + 1'b1;
                LOAD_X: if (s_valid) begin
                    if (wcnt == X_LAST) begin
                        wcnt <= '0;
                        row  <= '0;
                        col  <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ISSUE:   col <= (col == C_LAST) ? '0 : col + 1'b1;
                CLR_ROW: begin
                    row <= (row == R_LAST) ? '0 : row + 1'b1;
                    col <= '0;
                end
                CLEAR_INIT: wcnt <= '0;
                default: ;
            endcase
            // Strobes may already arrive while the row is still issuing.
            if (state == ISSUE || state == DRAIN) begin
                if (mac_valid_out && pcnt != P_DONE) pcnt <= pcnt + 1'b1;
            end else begin
                pcnt <= '0;
            end
        end
    end

    // Operand valid trails the read issue by the memory latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) issue_d <= 1'b0;
        else        issue_d <= (state == ISSUE);
    end

    // Capture the finished row sum one cycle after its final strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                y_data <= '0;
        else if (state == DRAIN && pcnt == P_DONE) y_data <= mac_f;
    end

endmodule

// File: tb/tb_mvm_mac_ctrl.sv
// Bench for mvm_mac_ctrl: sync-read memories and a 2-stage saturating MAC
// model around the controller, table-driven jobs plus backpressure and
// mid-job reset sequences.
module tb_mvm_mac_ctrl;
    localparam int ROWS = 3, COLS = 3, MA_W = 4, XA_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [9:0]      s_data;
    logic            s_valid;
    logic            s_ready;
    logic            m_wr_en;
    logic [MA_W-1:0] m_addr;
    logic [9:0]      m_wdata;
    logic [9:0]      m_rdata;
    logic            x_wr_en;
    logic [XA_W-1:0] x_addr;
    logic [9:0]      x_wdata;
    logic [9:0]      x_rdata;
    logic [9:0]      mac_a, mac_b;
    logic            mac_valid_in, mac_clear;
    logic [19:0]     mac_f;
    logic            mac_valid_out;
    logic [19:0]     y_data;
    logic            y_valid, y_ready;

    always #5 clk = ~clk;

    mvm_mac_ctrl #(.ROWS(ROWS), .COLS(COLS), .MA_W(MA_W), .XA_W(XA_W)) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .x_wr_en(x_wr_en), .x_addr(x_addr), .x_wdata(x_wdata), .x_rdata(x_rdata),
        .mac_a(mac_a), .mac_b(mac_b), .mac_valid_in(mac_valid_in), .mac_clear(mac_clear),
        .mac_f(mac_f), .mac_valid_out(mac_valid_out),
        .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
    );

    // Synchronous-read memories
    logic [9:0] m_mem [0:15];
    logic [9:0] x_mem [0:3];
    always @(posedge clk) begin
        if (m_wr_en) m_mem[m_addr] <= m_wdata;
        if (x_wr_en) x_mem[x_addr] <= x_wdata;
        m_rdata <= m_mem[m_addr];
        x_rdata <= x_mem[x_addr];
    end

    // Saturating MAC model: multiply stage, then accumulate stage
    logic signed [19:0] acc, prod;
    logic               v1, vo;
    int                 sum;
    always_comb begin
        sum = int'(acc) + int'(prod);
        if (sum > 524287)       sum = 524287;
        else if (sum < -524288) sum = -524288;
    end
    always @(posedge clk) begin
        if (mac_clear) begin
            acc <= '0; prod <= '0; v1 <= 1'b0; vo <= 1'b0;
        end else begin
            prod <= $signed(mac_a) * $signed(mac_b);
            v1   <= mac_valid_in;
            vo   <= v1;
            if (v1) acc <= 20'(sum);
        end
    end
    assign mac_f         = acc;
    assign mac_valid_out = vo;

    // Monitor
    int     mvi_cnt = 0, mclr_cnt = 0, ovl_cnt = 0;
    int     mq[$], xq[$];
    longint yq[$];
    always @(posedge clk) begin
        if (reset) begin
            if (m_wr_en) mq.push_back(int'(m_addr));
            if (x_wr_en) xq.push_back(int'(x_addr));
            if (y_valid && y_ready) yq.push_back(longint'($signed(y_data)));
            if (mac_valid_in) mvi_cnt <= mvi_cnt + 1;
            if (mac_clear) mclr_cnt <= mclr_cnt + 1;
            if (mac_valid_in && mac_clear) ovl_cnt <= ovl_cnt + 1;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [8:0][9:0]  m;
        logic [2:0][9:0]  x;
        logic [2:0][19:0] y;
        int               gap;
    } vec_t;
    vec_t vec [5];

    task automatic set_vec(input int i, input int mv[9], input int xv[3], input int yv[3], input int g);
        for (int k = 0; k < 9; k++) vec[i].m[k] = 10'(mv[k]);
        for (int k = 0; k < 3; k++) vec[i].x[k] = 10'(xv[k]);
        for (int k = 0; k < 3; k++) vec[i].y[k] = 20'(yv[k]);
        vec[i].gap = g;
    endtask

    task automatic wait_ready(input string nm);
        int t = 0;
        while (!s_ready && t < 50) begin @(negedge clk); t++; end
        chk(nm, longint'(s_ready), 1);
    endtask

    task automatic load_job(input int i);
        for (int w = 0; w < 12; w++) begin
            if (!s_ready) wait_ready("load_s_ready");
            s_data  = (w < 9) ? vec[i].m[w] : vec[i].x[w-9];
            s_valid = 1'b1;
            @(negedge clk);
            s_valid = 1'b0;
            repeat (2*vec[i].gap) @(negedge clk);
        end
    endtask

    task automatic check_job(input int i, input int bmvi, input int bclr);
        int t = 0;
        bit ok;
        while (yq.size() < 3 && t < 400) begin @(negedge clk); t++; end
        chk("y_count", yq.size(), 3);
        for (int r = 0; r < 3; r++)
            if (r < yq.size()) chk($sformatf("job%0d_y%0d", i, r), yq[r], longint'($signed(vec[i].y[r])));
        wait_ready("s_ready_after_job");
        chk("m_wr_count", mq.size(), 9);
        ok = 1'b1;
        foreach (mq[k]) if (mq[k] != k) ok = 1'b0;
        chk("m_addr_seq", longint'(ok), 1);
        chk("x_wr_count", xq.size(), 3);
        ok = 1'b1;
        foreach (xq[k]) if (xq[k] != k) ok = 1'b0;
        chk("x_addr_seq", longint'(ok), 1);
        chk("mac_valid_in_pulses", mvi_cnt - bmvi, 9);
        chk("mac_clear_pulses", mclr_cnt - bclr, 3);
        chk("valid_during_clear", ovl_cnt, 0);
    endtask

    task automatic clear_logs();
        mq.delete(); xq.delete(); yq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bmvi, bclr, t, bad;
        logic [19:0] d0;

        set_vec(0, '{1,0,0, 0,1,0, 0,0,1},             '{1,2,3},      '{1,2,3},             0);
        set_vec(1, '{511,511,511, 1,0,0, 0,0,0},       '{511,511,511}, '{524287,511,0},     0);
        set_vec(2, '{-512,-512,-512, -1,2,-3, 3,-4,5}, '{511,511,511}, '{-524288,-1022,2044}, 0);
        set_vec(3, '{1,2,3, 4,5,6, 7,8,9},             '{-1,2,-3},    '{-6,-12,-18},        1);
        set_vec(4, '{10,-20,30, -5,0,5, 100,100,100},  '{7,8,-9},     '{-360,-80,600},      0);

        reset = 1'b1; s_valid = 1'b0; s_data = '0; y_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_mac_clear", mac_clear, 1);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_data", y_data, 0);
        chk("rst_mac_valid_in", mac_valid_in, 0);
        chk("rst_wr_en", {m_wr_en, x_wr_en}, 0);
        chk("rst_addr", {m_addr, x_addr}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("init_clear", {mac_clear, s_ready}, 2'b10);
        @(negedge clk);
        chk("init_load_m", {mac_clear, s_ready}, 2'b01);

        // Table-driven jobs, output always ready
        y_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            clear_logs();
            bmvi = mvi_cnt; bclr = mclr_cnt;
            load_job(i);
            check_job(i, bmvi, bclr);
        end

        // Backpressure on the first row result
        y_ready = 1'b0;
        clear_logs();
        load_job(1);
        t = 0;
        while (!y_valid && t < 200) begin @(negedge clk); t++; end
        chk("bp_y_valid", y_valid, 1);
        d0 = y_data; bmvi = mvi_cnt; bclr = mclr_cnt; bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!y_valid || y_data != d0 || mac_valid_in || mac_clear) bad++;
        end
        chk("bp_stable", bad, 0);
        chk("bp_y0", longint'($signed(d0)), 524287);
        chk("bp_no_mac_activity", (mvi_cnt - bmvi) + (mclr_cnt - bclr), 0);
        y_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_clear", {mac_clear, y_valid}, 2'b10);
        @(negedge clk);
        chk("bp_clear_single", mac_clear, 0);
        chk("bp_clear_count", mclr_cnt - bclr, 1);
        t = 0;
        while (yq.size() < 3 && t < 400) begin @(negedge clk); t++; end
        chk("bp_y_count", yq.size(), 3);
        if (yq.size() >= 3) begin
            chk("bp_y1", yq[1], 511);
            chk("bp_y2", yq[2], 0);
        end
        wait_ready("bp_s_ready_after");

        // Reset while the first row drains
        clear_logs();
        load_job(3);
        t = 0;
        while (!mac_valid_in && t < 100) begin @(negedge clk); t++; end
        chk("rd_saw_issue", mac_valid_in, 1);
        t = 0;
        while (mac_valid_in && t < 100) begin @(negedge clk); t++; end
        #1 reset = 1'b0;
        #1;
        chk("rd_async_outputs", {s_ready, y_valid, mac_valid_in, m_wr_en, x_wr_en}, 0);
        chk("rd_async_clear", mac_clear, 1);
        chk("rd_async_y_data", y_data, 0);
        chk("rd_async_addr", {m_addr, x_addr}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rd_init_clear", {mac_clear, s_ready}, 2'b10);
        @(negedge clk);
        chk("rd_init_load_m", {mac_clear, s_ready}, 2'b01);
        clear_logs();
        bmvi = mvi_cnt; bclr = mclr_cnt;
        load_job(4);
        check_job(4, bmvi, bclr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
